mult_div_unit: RTL and testbench

- Parametrised iterative multiply/divide unit for the multicycle MIPS datapath, holding the architectural HI/LO pair.
- Executes MULT, MULTU, DIV and DIVU at one bit per cycle, using a start/busy/done handshake with the control unit.
- Supports direct HI/LO writes for MTHI/MTLO. HI/LO are readable at all times for MFHI/MFLO into the register-bank write-data mux.

---
 rtl/mdu_pkg.sv | 25 ++
 rtl/mdu_cond_neg.sv | 12 +
 rtl/mult_div_unit.sv | 182 ++++++++++++++++++
 tb/tb_mult_div_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared types and op-decode helpers for the multiply/divide unit.
package mdu_pkg;

  typedef enum logic [1:0] {
    MULT  = 2'd0,
    MULTU = 2'd1,
    DIV   = 2'd2,
    DIVU  = 2'd3
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } mdu_state_t;

  function automatic logic is_signed(mdu_op_t op);
    return (op == MULT) || (op == DIV);
  endfunction

  function automatic logic is_div(mdu_op_t op);
    return (op == DIV) || (op == DIVU);
  endfunction

endpackage

// File: rtl/mdu_cond_neg.sv
// Combinational conditional two's-complement negate.
module mdu_cond_neg #(
  parameter int N = 32
) (
  input  logic [N-1:0] x_i,
  input  logic         neg_i,
  output logic [N-1:0] y_o
);

  assign y_o = neg_i ? (~x_i + N'(1)) : x_i;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO, one bit per cycle.
// MDU_DIVZERO_TRAP_EN: divide by zero skips CALC and flags div_zero.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  mdu_op_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_wr,
  input  logic             lo_wr,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int W     = WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);

`ifdef MDU_DIVZERO_TRAP_EN
  localparam bit DzTrap = 1'b1;
`else
  localparam bit DzTrap = 1'b0;
`endif

  mdu_state_t   state_q;
  logic [CNT_W-1:0] cnt_q;
  logic         div_q;
  logic         neg_q;
  logic         rsgn_q;
  logic         bz_q;
  logic         busy_q;
  logic         done_q;
  logic         dz_q;
  logic [W-1:0] mcand_q;
  logic [2*W-1:0] acc_q;
  logic [W-1:0] hi_q;
  logic [W-1:0] lo_q;

  logic         sgn_in;
  logic         div_in;
  logic         bz_in;
  logic [W-1:0] abs_a;
  logic [W-1:0] abs_b;

  assign sgn_in = is_signed(op);
  assign div_in = is_div(op);
  assign bz_in  = div_in && (b == '0);

  mdu_cond_neg #(.N(W)) u_abs_a (
    .x_i   (a),
    .neg_i (sgn_in & a[W-1]),
    .y_o   (abs_a)
  );

  mdu_cond_neg #(.N(W)) u_abs_b (
    .x_i   (b),
    .neg_i (sgn_in & b[W-1]),
    .y_o   (abs_b)
  );

  // Multiply: acc = {partial, multiplier}; divide: acc = {rem, dividend/quot}
  logic [W:0]     msum;
  logic [2*W-1:0] mul_nxt;
  logic [W:0]     trial;
  logic [W-1:0]   rdiff;
  logic           ge;
  logic [2*W-1:0] div_nxt;
  logic [2*W-1:0] acc_d;

  always_comb begin
    msum    = {1'b0, acc_q[2*W-1:W]} + {1'b0, mcand_q & {W{acc_q[0]}}};
    mul_nxt = {msum, acc_q[W-1:1]};
    trial   = {acc_q[2*W-1:W], acc_q[W-1]};
    ge      = trial >= {1'b0, mcand_q};
    rdiff   = trial[W-1:0] - mcand_q;
    div_nxt = {ge ? rdiff : trial[W-1:0], acc_q[W-2:0], ge};
    acc_d   = div_q ? div_nxt : mul_nxt;
  end

  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix;
  logic [W-1:0]   rem_fix;
  logic [W-1:0]   res_hi;
  logic [W-1:0]   res_lo;

  mdu_cond_neg #(.N(2*W)) u_fix_prod (
    .x_i   (acc_q),
    .neg_i (neg_q),
    .y_o   (prod_fix)
  );

  mdu_cond_neg #(.N(W)) u_fix_quo (
    .x_i   (acc_q[W-1:0]),
    .neg_i (neg_q),
    .y_o   (quo_fix)
  );

  mdu_cond_neg #(.N(W)) u_fix_rem (
    .x_i   (acc_q[2*W-1:W]),
    .neg_i (rsgn_q),
    .y_o   (rem_fix)
  );

  // Zero divisor leaves |a| in the remainder, so hi already equals a
  always_comb begin
    res_hi = prod_fix[2*W-1:W];
    res_lo = prod_fix[W-1:0];
    if (div_q) begin
      res_hi = rem_fix;
      res_lo = bz_q ? '1 : quo_fix;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rsgn_q  <= 1'b0;
      bz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      mcand_q <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (hi_wr) hi_q <= wr_data;
          if (lo_wr) lo_q <= wr_data;
          if (start) begin
            div_q   <= div_in;
            neg_q   <= sgn_in & (a[W-1] ^ b[W-1]);
            rsgn_q  <= sgn_in & a[W-1];
            bz_q    <= bz_in;
            mcand_q <= div_in ? abs_b : abs_a;
            acc_q   <= {{W{1'b0}}, div_in ? abs_a : abs_b};
            cnt_q   <= CNT_W'(W);
            busy_q  <= 1'b1;
            state_q <= (DzTrap && bz_in) ? FIX : CALC;
          end
        end
        CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= FIX;
        end
        FIX: begin
          if (!(DzTrap && bz_q)) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
          end
          dz_q    <= DzTrap & bz_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: arithmetic reference model plus directed vectors.
module tb_mult_div_unit;
  import mdu_pkg::*;

  localparam int W = 32;
`ifdef MDU_DIVZERO_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  mdu_op_t       op;
  logic [W-1:0]  a, b, wr_data;
  logic          hi_wr, lo_wr;
  logic          busy, done, div_zero;
  logic [W-1:0]  hi, lo;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .hi_wr    (hi_wr),
    .lo_wr    (lo_wr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // {hi, lo} an operation must produce, from plain integer arithmetic
  function automatic logic [63:0] model_res(input logic [1:0] o,
                                            input logic [31:0] av,
                                            input logic [31:0] bv);
    longint sa, sb, p, q, r;
    logic [63:0] u;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    u  = '0;
    case (o)
      2'd0: begin p = sa * sb; u = p; end
      2'd1: u = {32'b0, av} * {32'b0, bv};
      2'd2: begin
        if (bv == 0) u = {av, 32'hFFFFFFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          u = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (bv == 0) u = {av, 32'hFFFFFFFF};
        else u = {av % bv, av / bv};
      end
    endcase
    return u;
  endfunction

  logic [31:0] m_hi = '0, m_lo = '0;
  logic        m_busy = 0, m_done = 0, m_dz = 0, m_trap = 0;
  logic [63:0] m_res = '0;
  int          m_rem = 0;

  // Cycle-level reference: result lands WIDTH+1 edges after start
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hi = '0; m_lo = '0; m_busy = 0; m_done = 0; m_dz = 0; m_rem = 0;
    end else begin
      m_done = 0;
      m_dz   = 0;
      if (!m_busy) begin
        if (start) begin
          m_res  = model_res(op, a, b);
          m_trap = TRAP && op[1] && (b == 0);
          m_rem  = m_trap ? 1 : W + 1;
          m_busy = 1;
        end
        if (hi_wr) m_hi = wr_data;
        if (lo_wr) m_lo = wr_data;
      end else begin
        m_rem--;
        if (m_rem == 0) begin
          m_busy = 0;
          m_done = 1;
          m_dz   = m_trap;
          if (!m_trap) {m_hi, m_lo} = m_res;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("div_zero", 32'(div_zero), 32'(m_dz));
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
      chk("busy_done_excl", 32'(busy & done), 32'd0);
    end
  end

  task automatic do_op(input logic [1:0] o, input logic [31:0] av,
                       input logic [31:0] bv, input logic [31:0] ehi,
                       input logic [31:0] elo, input int elat,
                       input logic edz, input string nm);
    int lat, bcnt;
    @(negedge clk); #1;
    start = 1; op = mdu_op_t'(o); a = av; b = bv;
    @(posedge clk); #1;
    start = 0;
    lat = 0;
    bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_lat"}, lat, elat);
    chk({nm, "_busycyc"}, bcnt, elat);
    chk({nm, "_hi"}, hi, ehi);
    chk({nm, "_lo"}, lo, elo);
    chk({nm, "_dz"}, 32'(div_zero), 32'(edz));
  endtask

  initial begin
    int dcnt;
    reset = 1; start = 0; op = MULT; a = '0; b = '0;
    hi_wr = 0; lo_wr = 0; wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset = 0;
    chk_en = 1;

    do_op(2'd0, 32'hFFFFFFFD, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFF1, 33, 0, "mult");
    do_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 33, 0, "multu");
    do_op(2'd3, 32'd100, 32'd7, 32'h2, 32'hE, 33, 0, "divu");
    do_op(2'd2, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 0, "div");
    do_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 33, 0, "divovf");

    @(negedge clk); #1;
    lo_wr = 1; wr_data = 32'hCAFEF00D;
    @(posedge clk); #1;
    lo_wr = 0;
    chk("mtlo_lo", lo, 32'hCAFEF00D);
    chk("mtlo_hi", hi, 32'h0);

    do_op(2'd3, 32'h1234, 32'h0,
          TRAP ? 32'h0 : 32'h1234,
          TRAP ? 32'hCAFEF00D : 32'hFFFFFFFF,
          TRAP ? 1 : 33, TRAP, "divz");

    @(negedge clk); #1;
    start = 1; op = MULTU; a = 32'd6; b = 32'd7;
    @(posedge clk); #1;
    start = 0;
    repeat (5) @(posedge clk);
    #1;
    start = 1; op = DIVU; a = 32'd9; b = 32'd3;
    hi_wr = 1; wr_data = 32'hDEADBEEF;
    @(posedge clk); #1;
    start = 0; hi_wr = 0;
    dcnt = 0;
    repeat (45) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    chk("busy_ign_dones", dcnt, 1);
    chk("busy_ign_hi", hi, 32'h0);
    chk("busy_ign_lo", lo, 32'h2A);

    @(negedge clk); #1;
    start = 1; op = MULT; a = 32'd3; b = 32'd4;
    @(posedge clk); #1;
    start = 0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1;
    #1;
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_hi", hi, 32'h0);
    chk("rstmid_lo", lo, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    dcnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    chk("rstmid_nodone", dcnt, 0);

    do_op(2'd0, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2, 33, 0, "postrst");

    @(negedge clk);
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
